data_mem_responder: RTL

//  Data-memory responder: the target end of the core's load/store interface. Accepts one

---
 rtl/riscv_pkg.sv | 15 +
 rtl/mem_lane_align.sv | 57 +++++
 rtl/data_mem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// encodings and the responder state enumeration.
package riscv_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_e;
endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one RV32I load/store: byte enables, store merge into
// the old word, sign/zero-extended load data and alignment/funct3 error.
module mem_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wmerged,
    output logic [31:0] rdata_ext,
    output logic        lane_err
);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] wrep;

    always_comb begin
        sel_byte  = old_word[{lane, 3'b000} +: 8];
        sel_half  = lane[1] ? old_word[31:16] : old_word[15:0];
        byte_en   = 4'b0000;
        wrep      = wdata;
        rdata_ext = 32'd0;
        lane_err  = 1'b0;
        wmerged   = old_word;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en   = 4'b0001 << lane;
                wrep      = {4{wdata[7:0]}};
                rdata_ext = (funct3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'd0, sel_byte};
                lane_err  = is_store && (funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                wrep      = {2{wdata[15:0]}};
                rdata_ext = (funct3 == F3_H) ? {{16{sel_half[15]}}, sel_half} : {16'd0, sel_half};
                lane_err  = lane[0] || (is_store && (funct3 == F3_HU));
            end
            F3_W: begin
                byte_en   = 4'b1111;
                rdata_ext = old_word;
                lane_err  = (lane != 2'b00);
            end
            default: lane_err = 1'b1;
        endcase
        // An erroring access must neither touch any lane nor return data.
        if (lane_err) begin
            byte_en   = 4'b0000;
            rdata_ext = 32'd0;
        end
        for (int i = 0; i < 4; i++) begin
            wmerged[8*i +: 8] = byte_en[i] ? wrep[8*i +: 8] : old_word[8*i +: 8];
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// Target end of the core's load/store interface: one request at a time over
// valid/ready, RV32I byte/half/word access to a word RAM, fixed-latency response.
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0] LAT_M1 = (LATENCY > 0) ? 2'(LATENCY - 1) : 2'd0;

    rsp_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [31:0] old_word, wmerged, rdata_ext;
    logic [3:0]  byte_en;
    logic        lane_err, range_err, err_all, commit, mem_we;

    assign word_idx  = addr_q[AW+1:2];
    assign old_word  = mem[word_idx];
    assign range_err = (addr_q[31:2] >= 30'(DEPTH_WORDS));
    assign err_all   = lane_err || range_err;
    // First RESP cycle is the commit cycle; rsp_valid rises on the edge ending it.
    assign commit    = (state_q == RESP) && !rsp_valid_q;
    assign mem_we    = commit && we_q && !range_err && (|byte_en);

    mem_lane_align u_align (
        .funct3    (f3_q),
        .is_store  (we_q),
        .lane      (addr_q[1:0]),
        .wdata     (wdata_q),
        .old_word  (old_word),
        .byte_en   (byte_en),
        .wmerged   (wmerged),
        .rdata_ext (rdata_ext),
        .lane_err  (lane_err)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 2'd1;
            end
            RESP: begin
                if (commit) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_all;
                    rsp_rdata_d = (we_q || err_all) ? 32'd0 : rdata_ext;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[word_idx] <= wmerged;
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule
